packet_requester: RTL
=====================

PACKET_REQUESTER -- requirements
Module: packet_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: flit payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: input buffer depth in flits, a power of two of at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_flit_id (input, 3 bits) and in_data (input, DATA_W bits): the upstream flit handshake.
REQ-006 The block SHALL have port req, output, 1 bit: request to the router arbiter for this port.
REQ-007 The block SHALL have port flit_id, output, 3 bits: type of the flit at the buffer head, presented to the arbiter timer.
REQ-008 The block SHALL have port length, output, 12 bits: packet length taken from the current header, presented to the arbiter timer.
REQ-009 The block SHALL have port grant, input, 1 bit: this port's one-hot bit of the arbiter state.
REQ-010 The block SHALL have ports out_valid (output, 1 bit) and out_data (output, DATA_W bits): the flit forwarded toward the crossbar.
REQ-011 The block SHALL have port preempt_cnt, output, 8 bits: saturating count of grants lost mid-packet.
REQ-012 The block SHALL have port err_proto, output, 1 bit: sticky flag for protocol violations.

Function
REQ-013 Flit encoding SHALL be 3'b001 header, 3'b010 body, 3'b100 tail; the header carries the packet length in in_data[11:0].
REQ-014 in_ready SHALL equal "buffer not full"; a flit SHALL be written when in_valid && in_ready, with no write-through to the outputs.
REQ-015 A pop from a full buffer SHALL free space visible on in_ready the following cycle only.
REQ-016 The FSM SHALL have four states: IDLE, REQ, SEND and HOLD.
REQ-017 In IDLE, req SHALL be 0; a header at the buffer head SHALL move the FSM to REQ next cycle.
REQ-018 In IDLE, a body or tail at the head SHALL be popped and discarded, and err_proto SHALL be set.
REQ-019 In REQ, SEND and HOLD, req SHALL be 1 and flit_id SHALL equal the head flit's id; otherwise flit_id SHALL be 3'b000.
REQ-020 out_valid SHALL equal req && grant && buffer not empty && state != HOLD, combinationally.
REQ-021 out_data SHALL equal the head flit's data; the head SHALL be popped in the same cycle as out_valid.
REQ-022 In REQ, when the header is popped, length SHALL register in_data[11:0] of that header and the FSM SHALL move to SEND.
REQ-023 In SEND, an empty buffer SHALL give out_valid=0 while the FSM stays in SEND with req held at 1.
REQ-024 In SEND, popping a tail SHALL return the FSM to IDLE; at least one idle cycle then separates packets.
REQ-025 In SEND, a header at the head SHALL not be popped; err_proto SHALL be set and the FSM SHALL return to IDLE.
REQ-026 In SEND, grant=0 while the buffer is non-empty SHALL move the FSM to HOLD and increment preempt_cnt, saturating at 255.
REQ-027 In HOLD, req SHALL be 1 and nothing SHALL be emitted; grant=1 SHALL return the FSM to SEND.
REQ-028 When a single-flit header is immediately followed by a tail, the tail SHALL be emitted on the next granted cycle.

Reset
REQ-029 Reset SHALL be asynchronous and active-high, and SHALL clear state to IDLE, empty the buffer, and zero length, preempt_cnt and err_proto.
REQ-030 During reset, req, out_valid and flit_id SHALL be 0 and in_ready SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL discard all buffered flits, with no partial packet emitted afterward.

Structure
REQ-032 The flit-id constants (HDR, BODY, TAIL), the state encoding and LEN_W=12 SHALL live in a shared noc_pkg package, which the arbiter also uses.
REQ-033 The buffer SHALL be one sub-module, flit_fifo, parameterised by DATA_W+3 and DEPTH, providing full, empty, push and pop; the FSM SHALL remain in packet_requester.

Verification
REQ-034 Header with length 5, two bodies, then a tail, with grant held 1 -> req rises one cycle after the header is buffered; four out_valid pulses; length=5; FSM back to IDLE.
REQ-035 Grant dropped for 3 cycles after the first body -> FSM enters HOLD, preempt_cnt=1, req stays 1, no out_valid, and the remaining flits resume in order.
REQ-036 Five flits pushed with DEPTH=4 and grant=0 -> in_ready=0 after four writes; the fifth is accepted one cycle after the first pop.
REQ-037 Body flit arriving while IDLE -> the flit is discarded, err_proto=1, req stays 0.
REQ-038 rst pulsed after the header has been sent -> req=0, buffer empty and length=0 immediately, and no stale flits are emitted afterward.
REQ-039 256 preemptions -> preempt_cnt saturates at 255.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit encodings, length width and requester state encoding
package noc_pkg;

  localparam int LEN_W = 12;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } req_state_t;

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous flit buffer with registered full/empty and a combinational head
module flit_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  // Extra pointer bit tells a wrapped (full) buffer apart from an empty one.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/packet_requester.sv
// rtl/packet_requester.sv - buffers flits, requests the arbiter per packet and forwards granted flits
module packet_requester
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        preempt_cnt,
  output logic              err_proto
);

  req_state_t         r_state;
  req_state_t         w_state_nxt;
  logic [LEN_W-1:0]   r_length;
  logic [7:0]         r_preempt;
  logic               r_err;

  logic [DATA_W+2:0]  w_head;
  logic [2:0]         w_head_id;
  logic [DATA_W-1:0]  w_head_data;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_err;
  logic               w_preempt;
  logic               w_len_load;

  assign in_ready    = !w_full && !rst;
  assign w_push      = in_valid && in_ready;
  assign w_head_id   = w_head[DATA_W+2:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign out_data    = w_head_data;
  assign length      = r_length;
  assign preempt_cnt = r_preempt;
  assign err_proto   = r_err;

  flit_fifo #(
    .W     (DATA_W + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({in_flit_id, in_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_preempt   = 1'b0;
    w_len_load  = 1'b0;
    req         = (r_state != IDLE);
    flit_id     = (req && !w_empty) ? w_head_id : 3'b000;
    // A stray header mid-packet is never forwarded, so it must not raise out_valid.
    out_valid   = req && grant && !w_empty && (r_state != HOLD) &&
                  !((r_state == SEND) && (w_head_id == HDR));

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_head_id == HDR) begin
            w_state_nxt = REQ;
          end else begin
            w_pop = 1'b1;
            w_err = 1'b1;
          end
        end
      end
      REQ: begin
        if (out_valid) begin
          w_pop       = 1'b1;
          w_len_load  = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!w_empty) begin
          if (w_head_id == HDR) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else if (!grant) begin
            w_preempt   = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_pop = 1'b1;
            if (w_head_id == TAIL) w_state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (grant) w_state_nxt = SEND;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_length  <= '0;
      r_preempt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_len_load) r_length <= w_head_data[LEN_W-1:0];
      if (w_preempt && (r_preempt != 8'hFF)) r_preempt <= r_preempt + 8'd1;
      if (w_err) r_err <= 1'b1;
    end
  end

endmodule
